// File: rtl/svc_axi_sram_if_wr_pkg.sv
// Shared AXI encodings for the AXI-to-SRAM bridge halves.
// Burst types and response codes are used by both the read and write blocks.
package svc_axi_sram_if_wr_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/svc_axi_sram_if_wr.sv
// AXI4 write slave (AW/W/B): each accepted W beat becomes one SRAM word write
// command. One burst in flight at a time; every burst is answered with OKAY.
module svc_axi_sram_if_wr
  import svc_axi_sram_if_wr_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int AXI_ID_WIDTH   = 4,
  localparam int LSB   = $clog2(AXI_DATA_WIDTH) - 3,
  localparam int SAW   = AXI_ADDR_WIDTH - LSB,
  localparam int STRBW = AXI_DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,

  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRBW-1:0]          s_axi_wstrb,
  input  logic                      s_axi_wlast,

  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]                s_axi_bresp,

  output logic                      sram_wr_cmd_valid,
  input  logic                      sram_wr_cmd_ready,
  output logic [SAW-1:0]            sram_wr_cmd_addr,
  output logic [AXI_DATA_WIDTH-1:0] sram_wr_cmd_data,
  output logic [STRBW-1:0]          sram_wr_cmd_strb
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN, RESP} state_e;

  state_e                    state;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_ADDR_WIDTH-1:0] cur_addr;
  logic [2:0]                size_q;
  burst_e                    burst_q;
  logic [7:0]                cnt_q;

  logic                      aw_hs;
  logic                      w_hs;
  logic                      cmd_free;
  logic [AXI_ADDR_WIDTH-1:0] beat_addr;
  logic [AXI_ADDR_WIDTH-1:0] next_addr;
  logic [2:0]                beat_size;
  burst_e                    beat_burst;
  logic [7:0]                beat_cnt;
  logic                      last_beat;

  // Burst termination is counted from awlen; wlast carries no information here.
  logic unused_wlast;
  assign unused_wlast = s_axi_wlast;

  assign aw_hs    = s_axi_awvalid && s_axi_awready;
  assign cmd_free = !sram_wr_cmd_valid || sram_wr_cmd_ready;
  assign s_axi_wready = ((state == BURST) || aw_hs) && cmd_free;
  assign w_hs     = s_axi_wvalid && s_axi_wready;

  // On the AW handshake cycle the burst context comes straight from the AW
  // channel, so a single-beat write can complete AW and W together.
  always_comb begin
    // NOTE: combinational outputs get a default on every path so no latch is inferred.
    beat_addr  = cur_addr;
    beat_size  = size_q;
    beat_burst = burst_q;
    beat_cnt   = cnt_q;
    if (aw_hs) begin
      beat_addr  = s_axi_awaddr;
      beat_size  = s_axi_awsize;
      beat_burst = burst_e'(s_axi_awburst);
      beat_cnt   = s_axi_awlen;
    end
    next_addr = (beat_burst == BURST_FIXED) ? beat_addr
                                            : beat_addr + (AXI_ADDR_WIDTH'(1) << beat_size);
    last_beat = (beat_cnt == 8'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      s_axi_awready     <= 1'b1;
      s_axi_bvalid      <= 1'b0;
      s_axi_bid         <= '0;
      s_axi_bresp       <= RESP_OKAY;
      sram_wr_cmd_valid <= 1'b0;
      sram_wr_cmd_addr  <= '0;
      sram_wr_cmd_data  <= '0;
      sram_wr_cmd_strb  <= '0;
      id_q              <= '0;
      cur_addr          <= '0;
      size_q            <= '0;
      burst_q           <= BURST_FIXED;
      cnt_q             <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; later assignments below override earlier ones.
      if (w_hs) begin
        sram_wr_cmd_valid <= 1'b1;
        sram_wr_cmd_addr  <= beat_addr[AXI_ADDR_WIDTH-1:LSB];
        sram_wr_cmd_data  <= s_axi_wdata;
        sram_wr_cmd_strb  <= s_axi_wstrb;
        cur_addr          <= next_addr;
        cnt_q             <= beat_cnt - 8'd1;
      end else if (sram_wr_cmd_valid && sram_wr_cmd_ready) begin
        sram_wr_cmd_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (aw_hs) begin
            id_q          <= s_axi_awid;
            size_q        <= s_axi_awsize;
            burst_q       <= burst_e'(s_axi_awburst);
            s_axi_awready <= 1'b0;
            if (!w_hs) begin
              cur_addr <= s_axi_awaddr;
              cnt_q    <= s_axi_awlen;
            end
            state <= (w_hs && last_beat) ? DRAIN : BURST;
          end
        end
        BURST: begin
          if (w_hs && last_beat) state <= DRAIN;
        end
        DRAIN: begin
          if (sram_wr_cmd_valid && sram_wr_cmd_ready) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bid    <= id_q;
            s_axi_bresp  <= RESP_OKAY;
            state        <= RESP;
          end
        end
        RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svc_axi_sram_if_wr.sv
// Directed self-checking bench for svc_axi_sram_if_wr with hand-computed
// expected SRAM commands and B responses.
module tb_svc_axi_sram_if_wr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [3:0]  s_axi_awid = '0;
  logic [19:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = '0;
  logic [1:0]  s_axi_awburst = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [15:0] s_axi_wdata = '0;
  logic [1:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b1;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        sram_wr_cmd_valid;
  logic        sram_wr_cmd_ready = 1'b1;
  logic [18:0] sram_wr_cmd_addr;
  logic [15:0] sram_wr_cmd_data;
  logic [1:0]  sram_wr_cmd_strb;

  int checks = 0;
  int failures = 0;
  int b_count = 0;
  logic [18:0] q_addr[$];
  logic [15:0] q_data[$];
  logic [1:0]  q_strb[$];

  svc_axi_sram_if_wr dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .sram_wr_cmd_valid(sram_wr_cmd_valid), .sram_wr_cmd_ready(sram_wr_cmd_ready),
    .sram_wr_cmd_addr(sram_wr_cmd_addr), .sram_wr_cmd_data(sram_wr_cmd_data),
    .sram_wr_cmd_strb(sram_wr_cmd_strb)
  );

  always #5 clk = ~clk;

  // Record every SRAM command and B response as it handshakes.
  always @(posedge clk) begin
    if (sram_wr_cmd_valid && sram_wr_cmd_ready) begin
      q_addr.push_back(sram_wr_cmd_addr);
      q_data.push_back(sram_wr_cmd_data);
      q_strb.push_back(sram_wr_cmd_strb);
    end
    if (s_axi_bvalid && s_axi_bready) b_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
    q_strb.delete();
  endtask

  // Present AW and all W beats; returns once every beat has handshaken.
  task automatic do_burst(input logic [3:0] id, input logic [19:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [15:0] data_base, input logic [1:0] strb);
    int beat = 0;
    int cyc = 0;
    logic awhs, whs;
    s_axi_awvalid = 1'b1; s_axi_awid = id; s_axi_awaddr = addr;
    s_axi_awlen = len; s_axi_awsize = size; s_axi_awburst = burst;
    s_axi_wvalid = 1'b1; s_axi_wdata = data_base; s_axi_wstrb = strb;
    while (s_axi_wvalid && cyc < 200) begin
      #1;
      awhs = s_axi_awvalid && s_axi_awready;
      whs  = s_axi_wvalid && s_axi_wready;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (awhs) s_axi_awvalid = 1'b0;
      if (whs) begin
        beat++;
        s_axi_wdata = data_base + 16'(beat);
        if (beat > int'(len)) s_axi_wvalid = 1'b0;
      end
    end
    if (cyc >= 200) check("burst_timeout", 32'(beat), 32'(len) + 1);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
  endtask

  task automatic wait_b(input int target);
    int cyc = 0;
    while (b_count < target && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("b_wait", 32'(b_count), 32'(target));
  endtask

  initial begin
    int b0;
    int cyc;
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_valid", 32'(sram_wr_cmd_valid), 0);
    check("rst_bvalid", 32'(s_axi_bvalid), 0);
    check("rst_bresp", 32'(s_axi_bresp), 0);
    check("rst_awready", 32'(s_axi_awready), 1);
    check("rst_bid", 32'(s_axi_bid), 0);
    check("rst_cmd_addr", 32'(sram_wr_cmd_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single beat with SRAM stall
    sram_wr_cmd_ready = 1'b0; s_axi_bready = 1'b1;
    s_axi_awvalid = 1'b1; s_axi_awid = 4'hB; s_axi_awaddr = 20'hA000;
    s_axi_awlen = 8'd0; s_axi_awsize = 3'd1; s_axi_awburst = 2'd1;
    s_axi_wvalid = 1'b1; s_axi_wdata = 16'hD000; s_axi_wstrb = 2'b11;
    #1;
    check("sb_wready_with_aw", 32'(s_axi_wready), 1);
    @(posedge clk); @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sb_stall_valid", 32'(sram_wr_cmd_valid), 1);
      check("sb_stall_addr", 32'(sram_wr_cmd_addr), 32'h5000);
      check("sb_stall_data", 32'(sram_wr_cmd_data), 32'hD000);
      check("sb_stall_strb", 32'(sram_wr_cmd_strb), 32'h3);
      check("sb_stall_bvalid", 32'(s_axi_bvalid), 0);
      check("sb_stall_awready", 32'(s_axi_awready), 0);
      if (i < 2) begin @(posedge clk); @(negedge clk); end
    end
    sram_wr_cmd_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("sb_cmd_done", 32'(sram_wr_cmd_valid), 0);
    check("sb_bvalid", 32'(s_axi_bvalid), 1);
    check("sb_bid", 32'(s_axi_bid), 32'hB);
    check("sb_bresp", 32'(s_axi_bresp), 0);
    @(posedge clk); @(negedge clk);
    check("sb_bvalid_clr", 32'(s_axi_bvalid), 0);
    check("sb_awready_back", 32'(s_axi_awready), 1);

    // INCR burst, 4 beats of 2 bytes from 0x100
    clear_q(); b0 = b_count;
    do_burst(4'h3, 20'h00100, 8'd3, 3'd1, 2'd1, 16'h1111, 2'b11);
    wait_b(b0 + 1);
    repeat (3) @(negedge clk);
    check("incr_ncmd", 32'(q_addr.size()), 4);
    check("incr_nresp", 32'(b_count - b0), 1);
    check("incr_bid", 32'(s_axi_bid), 32'h3);
    for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
      check("incr_addr", 32'(q_addr[i]), 32'h80 + 32'(i));
      check("incr_data", 32'(q_data[i]), 32'h1111 + 32'(i));
    end

    // FIXED burst, 3 beats at 0x2468
    clear_q(); b0 = b_count;
    do_burst(4'h7, 20'h02468, 8'd2, 3'd1, 2'd0, 16'h4000, 2'b11);
    wait_b(b0 + 1);
    repeat (2) @(negedge clk);
    check("fixed_ncmd", 32'(q_addr.size()), 3);
    for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
      check("fixed_addr", 32'(q_addr[i]), 32'h1234);
      check("fixed_data", 32'(q_data[i]), 32'h4000 + 32'(i));
    end

    // B backpressure with a second AW waiting
    clear_q(); b0 = b_count;
    s_axi_bready = 1'b0;
    do_burst(4'h5, 20'h00010, 8'd0, 3'd1, 2'd1, 16'h5555, 2'b11);
    cyc = 0;
    while (!s_axi_bvalid && cyc < 50) begin @(negedge clk); cyc++; end
    check("bp_bvalid_seen", 32'(s_axi_bvalid), 1);
    s_axi_awvalid = 1'b1; s_axi_awid = 4'h6; s_axi_awaddr = 20'h00040;
    s_axi_awlen = 8'd0; s_axi_awburst = 2'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_bvalid_hold", 32'(s_axi_bvalid), 1);
      check("bp_awready_low", 32'(s_axi_awready), 0);
      check("bp_bid", 32'(s_axi_bid), 32'h5);
      @(posedge clk); @(negedge clk);
    end
    check("bp_no_extra_cmd", 32'(q_addr.size()), 1);
    s_axi_bready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp_bvalid_clr", 32'(s_axi_bvalid), 0);
    check("bp_one_resp", 32'(b_count - b0), 1);
    check("bp_awready_back", 32'(s_axi_awready), 1);
    do_burst(4'h6, 20'h00040, 8'd0, 3'd1, 2'd1, 16'h6666, 2'b11);
    wait_b(b0 + 2);
    @(negedge clk);
    check("bp_second_ncmd", 32'(q_addr.size()), 2);
    if (q_addr.size() >= 2) check("bp_second_addr", 32'(q_addr[1]), 32'h20);

    // Partial strobe
    clear_q(); b0 = b_count;
    do_burst(4'h1, 20'h00200, 8'd0, 3'd1, 2'd1, 16'hBEEF, 2'b01);
    wait_b(b0 + 1);
    check("strb_ncmd", 32'(q_strb.size()), 1);
    if (q_strb.size() >= 1) begin
      check("strb_partial", 32'(q_strb[0]), 32'h1);
      check("strb_addr", 32'(q_addr[0]), 32'h100);
      check("strb_data", 32'(q_data[0]), 32'hBEEF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
